// File: rtl/lsu_master_pkg.sv
// lsu_master_pkg: opcode/funct constants, FSM state encoding and opcode class helpers
// shared by the load/store master and its lane logic.
package lsu_master_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;

    localparam logic [5:0] OP_LB   = 6'h20;
    localparam logic [5:0] OP_LH   = 6'h21;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_LBU  = 6'h24;
    localparam logic [5:0] OP_LHU  = 6'h25;
    localparam logic [5:0] OP_SB   = 6'h28;
    localparam logic [5:0] OP_SH   = 6'h29;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] FN_JALR = 6'h09;

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SW, OP_SB, OP_SH};
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH};
    endfunction

    function automatic logic is_word(input logic [5:0] op);
        return op inside {OP_LW, OP_SW};
    endfunction

    function automatic logic is_half(input logic [5:0] op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction
endpackage

// File: rtl/lsu_master_lane.sv
// lsu_lane: store lane replication with byte enables, and load byte/half
// extraction with sign or zero extension.
module lsu_lane
    import lsu_master_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_o
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        be_o    = op_i == OP_SB ? 4'b0001 << lane_i :
                  op_i == OP_SH ? 4'b0011 << lane_i : 4'b1111;
        wdata_o = op_i == OP_SB ? {4{sdata_i[7:0]}} :
                  op_i == OP_SH ? {2{sdata_i[15:0]}} : sdata_i;
        b       = rdata_i[{lane_i, 3'b000} +: 8];
        h       = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_o    = op_i == OP_LB  ? {{24{b[7]}}, b} :
                  op_i == OP_LBU ? {24'h0, b} :
                  op_i == OP_LH  ? {{16{h[15]}}, h} :
                  op_i == OP_LHU ? {16'h0, h} : rdata_i;
    end
endmodule

// File: rtl/lsu_master.sv
// lsu_master: multi-cycle req/ack load/store initiator with timeout, misalignment
// detection and a unified register write-back mux.
module lsu_master
    import lsu_master_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] ins_i,
    input  logic [31:0] result_i,
    input  logic [31:0] rdata2_i,
    input  logic [31:0] next_pc_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] wdata_o,
    output logic        wdata_valid_o,
    output logic        misalign_exc_o,
    output logic        bus_err_o
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d, sdata_q, sdata_d, wb_q, wb_d;
    logic               mis_q, mis_d;
    logic [5:0]         op, fn;
    logic               mem_op, misal, req, unused_ok;
    logic [3:0]         be;
    logic [31:0]        lane_wdata, ld;

    assign op        = ins_i[31:26];
    assign fn        = ins_i[5:0];
    assign mem_op    = is_mem(op);
    assign misal     = is_word(op) ? |result_i[1:0] : is_half(op) & result_i[0];
    assign unused_ok = ^ins_i[25:6];

    lsu_lane u_lane (
        .op_i    (op_q),
        .lane_i  (addr_q[1:0]),
        .sdata_i (sdata_q),
        .rdata_i (mem_rdata_i),
        .be_o    (be),
        .wdata_o (lane_wdata),
        .ld_o    (ld)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            wb_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            wb_q    <= wb_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        wb_d    = wb_q;
        mis_d   = mis_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                op_d = op;
                if (mem_op && misal) begin
                    state_d = S_ERR;
                    mis_d   = 1'b1;
                end else if (mem_op) begin
                    state_d = S_REQ;
                    addr_d  = result_i;
                    sdata_d = rdata2_i;
                    cnt_d   = '0;
                end else begin
                    state_d = S_DONE;
                    wb_d    = (op == OP_JAL || (op == 6'h00 && fn == FN_JALR)) ? next_pc_i : result_i;
                end
            end
            // an ack on the timeout cycle still completes the access
            S_REQ: if (mem_ack_i) begin
                state_d = S_DONE;
                wb_d    = ld;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d = S_ERR;
                mis_d   = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req            = state_q == S_REQ;
        mem_req_o      = req;
        mem_we_o       = req & is_store(op_q);
        mem_addr_o     = {addr_q[31:2], 2'b00};
        mem_wdata_o    = req ? lane_wdata : '0;
        mem_be_o       = req ? be : '0;
        stall_o        = req | (state_q == S_IDLE & start_i & mem_op);
        wdata_o        = wb_q;
        wdata_valid_o  = state_q == S_DONE & ~is_store(op_q);
        misalign_exc_o = state_q == S_ERR & mis_q;
        bus_err_o      = state_q == S_ERR & ~mis_q;
    end
endmodule
